dec_entry_to_bin: RTL and testbench
===================================

# dec_entry_to_bin

Sequential decimal-entry converter: accepts decimal digits one at a time from the switch bank, each committed by a push-button press, and accumulates them into an unsigned binary value (value ← value·10 + digit). It is the input-side counterpart of the binary-to-decimal display path. It sits between the board switches/keys and any datapath needing a binary operand, and its `value` output can be looped back through the existing decimal display for confirmation.

## Interface
- `NDIG`, 3: maximum number of decimal digits accepted.
- `W`, 10: width of `value`. The wrapper must choose `W` ≥ ceil(log2(10^NDIG)); with the defaults, 999 fits in 10 bits.
- `CW`, 2: width of `count`, equal to ceil(log2(NDIG+1)).
- `Clock`, in, 1: single system clock. All state updates on the rising edge.
- `Resetn`, in, 1: asynchronous, active-low reset.
- `digit`, in, 4: BCD digit presented on the switches. It is sampled in the same cycle as the accepted press.
- `enter`, in, 1: active-high commit request, raw from a button and asynchronous to `Clock`.
- `clear`, in, 1: active-high level clear, raw and asynchronous.
- `value`, out, W: accumulated binary value.
- `count`, out, CW: number of digits accepted so far.
- `full`, out, 1: high when `count == NDIG`.
- `err`, out, 1: high after a non-BCD digit (>9) has been committed.
- `accepted`, out, 1: one-cycle pulse when a digit is added to `value`.

## Operation
- FSM states:
  - EMPTY: `count` = 0.
  - ENTRY: 0 < `count` < NDIG.
  - FULL: `count` = NDIG.
  - ERROR: a non-BCD digit was committed.
- Both `enter` and `clear` pass through a 2-flop synchronizer. `enter` additionally goes through a rising-edge detector (previous-sample register), which produces `press` for exactly one cycle per button press.
- On `press` in EMPTY or ENTRY:
  - If `digit` ≤ 9: `value` ← (`value`<<3) + (`value`<<1) + `digit`, `count` ← `count`+1, and `accepted` pulses. The next state is FULL if the new count equals NDIG, otherwise ENTRY.
  - If `digit` > 9: `value` and `count` are unchanged, the next state is ERROR, and `err` goes high.
- On `press` in FULL or ERROR: ignored. Nothing changes and `accepted` stays low.
- Synchronized `clear` high in any state: `value` = 0, `count` = 0, state EMPTY, `err` = 0.
- Arithmetic is computed at W+4 bits and truncated to W bits. Overflow cannot occur while `W` satisfies the parameter rule.
- Holding `enter` high produces exactly one press. A new press requires `enter` to go low for at least one synchronized cycle.

## Timing
- Reset (`Resetn` low, asynchronous): `value` = 0, `count` = 0, `full` = 0, `err` = 0, `accepted` = 0, state EMPTY. Synchronizer and edge-detect flops also go to 0, so an `enter` already held through reset release does not register as a press.
- Press latency: `enter` is first sampled high at edge k, so `press` is high between edges k+1 and k+2. `value`, `count` and `accepted` update at edge k+2. `accepted` stays high for one cycle.
- `digit` must be stable from edge k+1 through edge k+2.
- Clear latency: `clear` is sampled high at edge k and the registers are cleared at edge k+2. While synchronized `clear` is high, all presses are ignored.
- Simultaneous synchronized `clear` and `press`: clear wins and no digit is accepted.
- `full` and `err` are registered state decodes and are valid in the same cycle as the updated `count`.
- Reset asserted mid-sequence: the immediate asynchronous return to reset values above. Any press in flight is discarded.

## Structure
- Shared package holds:
  - the state enum {EMPTY, ENTRY, FULL, ERROR};
  - the default `NDIG`;
  - a BCD_MAX = 9 constant.
- Sub-module `sync_edge`: 2-flop synchronizer plus rising-edge pulse output. It is instantiated twice:
  - for `enter`, using the pulse output;
  - for `clear`, using only the synchronized level output.
- The core is a single FSM plus the `value`/`count` registers.

## Test plan
- Reset, then press digits 4, 0, 7 (`enter` held 5 cycles each, 5 cycles low between presses) -> `value` = 407 (0x197), `count` = 3, `full` = 1, three `accepted` pulses, each on the 3rd edge after `enter` rises.
- After `value` = 407 / FULL, press digit 5 -> `value` remains 407, no `accepted` pulse.
- Press 2, then press digit 0xB -> `err` = 1, `value` = 2, `count` = 1. A further press of 3 is ignored. Then `clear` -> everything returns to 0 and state is EMPTY.
- Hold `enter` high for 50 cycles with digit 9 -> exactly one `accepted` pulse, `value` = 9.
- `clear` and `enter` rise on the same edge with digit 6 -> `value` = 0, `count` = 0, no `accepted` pulse.
- Assert `Resetn` low between edges in the middle of a press with `value` = 12 -> outputs go to 0 immediately without a clock edge. After release with `enter` still high -> no digit is accepted.

Source files
------------

// File: rtl/dec_entry_to_bin_pkg.sv
// Shared types and constants for the decimal-entry converter.
// Defaults give a 3-digit entry into a 10-bit binary value.
package dec_entry_to_bin_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam int          NDIG_DEF = 3;
  localparam int          W_DEF    = 10;
  localparam int          CW_DEF   = 2;
  localparam logic [3:0]  BCD_MAX  = 4'd9;

endpackage

// File: rtl/dec_entry_to_bin_if.sv
// Switch/key inputs and result outputs of the decimal-entry converter.
// The master side drives the digit and buttons; the slave side is the converter.
interface dec_entry_to_bin_if
  import dec_entry_to_bin_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
);
  logic [3:0]    digit;
  logic          enter;
  logic          clear;
  logic [W-1:0]  value;
  logic [CW-1:0] count;
  logic          full;
  logic          err;
  logic          accepted;

  modport master (
    output digit, enter, clear,
    input  value, count, full, err, accepted
  );

  modport slave (
    input  digit, enter, clear,
    output value, count, full, err, accepted
  );
endinterface

// File: rtl/dec_entry_to_bin_sync_edge.sv
// Two-flop synchronizer with an optional rising-edge pulse output.
// EDGE_OUT=1 gives a one-cycle pulse per rise; EDGE_OUT=0 gives the synced level.
module sync_edge #(
  parameter bit EDGE_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  logic s1_q, s2_q, prev_q, vld_q, armed_q;
  logic s1_d, s2_d, prev_d, vld_d, armed_d;

  // armed_q only sets once a genuine low sample is seen after reset, so a
  // button already held through reset release never yields a pulse.
  always_comb begin
    s1_d    = din;
    s2_d    = s1_q;
    prev_d  = s2_q;
    vld_d   = 1'b1;
    armed_d = armed_q | (vld_q & ~s1_q);
    dout    = EDGE_OUT ? (s2_q & ~prev_q & armed_q) : s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      vld_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      vld_q   <= vld_d;
      armed_q <= armed_d;
    end
  end
endmodule

// File: rtl/dec_entry_to_bin.sv
// Sequential decimal entry: each accepted key press folds one BCD digit
// into value (value*10 + digit), up to NDIG digits.
module dec_entry_to_bin
  import dec_entry_to_bin_pkg::*;
#(
  parameter int NDIG = NDIG_DEF,
  parameter int W    = W_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic              Clock,
  input  logic              Resetn,
  dec_entry_to_bin_if.slave bus
);
  localparam logic [1:0] S_EMPTY = ST_EMPTY;
  localparam logic [1:0] S_ENTRY = ST_ENTRY;
  localparam logic [1:0] S_FULL  = ST_FULL;
  localparam logic [1:0] S_ERROR = ST_ERROR;

  logic          press, clr;
  logic [1:0]    state_q, state_d;
  logic [W-1:0]  value_q, value_d;
  logic [CW-1:0] count_q, count_d;
  logic          accepted_q, accepted_d;
  logic [W+3:0]  value_ext, value_x10;
  logic [CW-1:0] count_inc;

  sync_edge #(.EDGE_OUT(1'b1)) u_enter_sync (
    .clk   (Clock),
    .rst_n (Resetn),
    .din   (bus.enter),
    .dout  (press)
  );

  sync_edge #(.EDGE_OUT(1'b0)) u_clear_sync (
    .clk   (Clock),
    .rst_n (Resetn),
    .din   (bus.clear),
    .dout  (clr)
  );

  // value*10 as shift-and-add, with 4 bits of headroom before truncation
  assign value_ext = {4'b0000, value_q};
  assign value_x10 = (value_ext << 3) + (value_ext << 1) + (W+4)'(bus.digit);
  assign count_inc = count_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    count_d    = count_q;
    accepted_d = 1'b0;
    if (clr) begin
      state_d = S_EMPTY;
      value_d = '0;
      count_d = '0;
    end else if (press && (state_q == S_EMPTY || state_q == S_ENTRY)) begin
      if (bus.digit <= BCD_MAX) begin
        value_d    = value_x10[W-1:0];
        count_d    = count_inc;
        accepted_d = 1'b1;
        state_d    = (count_inc == CW'(NDIG)) ? S_FULL : S_ENTRY;
      end else begin
        state_d = S_ERROR;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_EMPTY;
      value_q    <= '0;
      count_q    <= '0;
      accepted_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      count_q    <= count_d;
      accepted_q <= accepted_d;
    end
  end

  assign bus.value    = value_q;
  assign bus.count    = count_q;
  assign bus.full     = (state_q == S_FULL);
  assign bus.err      = (state_q == S_ERROR);
  assign bus.accepted = accepted_q;
endmodule

// File: tb/tb_dec_entry_to_bin.sv
// Bench for dec_entry_to_bin: directed scenarios then random presses/clears,
// checked against a plain arithmetic model of the decimal entry.
module tb_dec_entry_to_bin;
  localparam int NDIG = 3;
  localparam int W    = 10;
  localparam int CW   = 2;

  logic clk;
  logic rst_n;

  dec_entry_to_bin_if #(.W(W), .CW(CW)) bus ();

  dec_entry_to_bin #(.NDIG(NDIG), .W(W), .CW(CW)) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;

  // reference model
  int m_value = 0;
  int m_count = 0;
  bit m_err   = 1'b0;

  always @(negedge clk) if (bus.accepted === 1'b1) acc_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".value"}, int'(bus.value), m_value);
    chk({tag, ".count"}, int'(bus.count), m_count);
    chk({tag, ".full"},  int'(bus.full),  (m_count == NDIG) ? 1 : 0);
    chk({tag, ".err"},   int'(bus.err),   int'(m_err));
  endtask

  // Apply one press and compare the pulse at the third edge after enter rises.
  task automatic press(input int d, input int hold, input int gap);
    int acc0;
    int exp_acc;
    exp_acc = 0;
    if (!m_err && m_count < NDIG) begin
      if (d <= 9) begin
        m_value = m_value * 10 + d;
        m_count = m_count + 1;
        exp_acc = 1;
      end else begin
        m_err = 1'b1;
      end
    end
    acc0 = acc_cnt;
    @(negedge clk);
    bus.digit = 4'(d);
    bus.enter = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("acc_early", int'(bus.accepted), 0);
    @(posedge clk);
    #1 chk("acc_k2", int'(bus.accepted), exp_acc);
    chk_outputs("press");
    $display("press digit=%0d hold=%0d value=%0d count=%0d full=%0d err=%0d acc=%0d",
             d, hold, bus.value, bus.count, bus.full, bus.err, bus.accepted);
    for (int i = 3; i < hold; i++) @(negedge clk);
    @(negedge clk);
    bus.enter = 1'b0;
    repeat (gap) @(negedge clk);
    chk("acc_pulses", acc_cnt - acc0, exp_acc);
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    m_value = 0;
    m_count = 0;
    m_err   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 chk_outputs("clear");
    $display("clear value=%0d count=%0d full=%0d err=%0d",
             bus.value, bus.count, bus.full, bus.err);
    @(negedge clk);
    bus.clear = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int acc0;
    rst_n     = 1'b0;
    bus.digit = 4'd0;
    bus.enter = 1'b0;
    bus.clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.acc", int'(bus.accepted), 0);
    chk_outputs("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 4, 0, 7 -> 407 and FULL
    press(4, 5, 5);
    press(0, 5, 5);
    press(7, 5, 5);
    chk("v407", int'(bus.value), 407);
    // ignored while full
    press(5, 5, 5);
    do_clear();

    // error path
    press(2, 5, 5);
    press(11, 5, 5);
    chk("err_value", int'(bus.value), 2);
    press(3, 5, 5);
    do_clear();

    // long hold gives a single accept
    press(9, 50, 5);
    chk("hold_value", int'(bus.value), 9);
    do_clear();

    // clear and enter together: clear wins
    acc0 = acc_cnt;
    @(negedge clk);
    bus.digit = 4'd6;
    bus.enter = 1'b1;
    bus.clear = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_outputs("clr_enter");
    repeat (3) @(negedge clk);
    bus.enter = 1'b0;
    bus.clear = 1'b0;
    repeat (5) @(negedge clk);
    chk("clr_enter.acc", acc_cnt - acc0, 0);
    $display("clear+enter value=%0d count=%0d", bus.value, bus.count);

    // async reset in the middle of a press
    press(1, 5, 5);
    press(2, 5, 5);
    chk("v12", int'(bus.value), 12);
    acc0 = acc_cnt;
    @(negedge clk);
    bus.digit = 4'd3;
    bus.enter = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_value = 0;
    m_count = 0;
    m_err   = 1'b0;
    #1 chk("arst.acc", int'(bus.accepted), 0);
    chk_outputs("arst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_held.acc", acc_cnt - acc0, 0);
    chk_outputs("arst_held");
    $display("reset mid-press value=%0d count=%0d", bus.value, bus.count);
    bus.enter = 1'b0;
    repeat (5) @(negedge clk);

    // random presses and clears
    for (int t = 0; t < 40; t++) begin
      int d;
      if ($urandom_range(0, 9) == 0 || ((m_err || m_count == NDIG) && $urandom_range(0, 1) == 1)) begin
        do_clear();
      end else begin
        d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
        press(d, int'($urandom_range(3, 8)), int'($urandom_range(3, 6)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
